csr_hpm_counters: RTL and testbench

- Parametrised counter CSR bank; successor to the fixed mcycle/minstret logic in the CSR unit.
- Implements mcycle, minstret, NUM_HPM programmable mhpmcounterN/mhpmeventN and mcountinhibit, all with configurable counter width.
- Adds multi-retire instret increment, event selection and Sscofpmf-style overflow interrupt.
- Sits beside the CSR unit; the CSR unit muxes rdata_o in when hit_o is set.

---
 rtl/csr_hpm_counters_pkg.sv | 41 ++++
 rtl/csr_hpm_counters_hpm_counter.sv | 45 ++++
 rtl/csr_hpm_counters.sv | 193 +++++++++++++++++++
 tb/tb_csr_hpm_counters.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_hpm_counters_pkg.sv
// CSR opcode type, counter CSR address map and field positions shared by the
// performance-counter bank and the CSR unit.
package csr_hpm_counters_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        WRITE_CSR = 2'b01,
        SET_CSR   = 2'b10,
        CLEAR_CSR = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

    localparam int HPM_OF_BIT   = 31;
    localparam int IDX_CYCLE    = 0;
    localparam int IDX_TIME     = 1;
    localparam int IDX_INSTRET  = 2;
    localparam int IDX_HPM_BASE = 3;

    function automatic logic csr_is_write(input csr_op_e op);
        return (op == WRITE_CSR) || (op == SET_CSR) || (op == CLEAR_CSR);
    endfunction

    function automatic logic [31:0] csr_modify(input csr_op_e op, input logic [31:0] old_val,
                                               input logic [31:0] operand);
        case (op)
            WRITE_CSR: return operand;
            SET_CSR:   return old_val | operand;
            CLEAR_CSR: return old_val & ~operand;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_hpm_counters_hpm_counter.sv
// One CNT_W-bit counter with independently writable 32-bit halves; a write to
// either half takes priority over (and cancels) this cycle's increment.
module hpm_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic [31:0]      wdata,
    input  logic             inc_en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] value,
    output logic             wrap
);

    logic [CNT_W-1:0] value_d;
    logic [CNT_W:0]   sum;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        sum     = {1'b0, value} + (CNT_W + 1)'(inc);
        value_d = value;
        wrap    = 1'b0;
        if (we_lo) begin
            value_d[31:0] = wdata;
        end else if (we_hi) begin
            value_d[CNT_W-1:32] = wdata[CNT_W-33:0];
        end else if (inc_en) begin
            value_d = sum[CNT_W-1:0];
            wrap    = sum[CNT_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            value <= '0;
        end else begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/csr_hpm_counters.sv
// Counter CSR bank: mcycle, minstret, programmable mhpmcounter/mhpmevent pairs,
// mcountinhibit and the counter-overflow interrupt.
module csr_hpm_counters
    import csr_hpm_counters_pkg::*;
#(
    parameter int          NUM_HPM       = 4,
    parameter int          CNT_W         = 64,
    parameter int          NUM_EVENTS    = 8,
    parameter int          RETIRE_W      = 2,
    parameter logic [31:0] INHIBIT_RESET = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  csr_op_e               csr_cmd_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  stop_counters_i,
    input  logic [RETIRE_W-1:0]   instret_inc_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic [31:0]           rdata_o,
    output logic                  hit_o,
    output logic                  ovf_irq_o
);

    localparam int          NUM_CNT      = IDX_HPM_BASE + NUM_HPM;
    localparam int          HPM_N        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int          EVW          = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

    logic [31:0]        inhibit;
    logic [EVW-1:0]     evt_sel [HPM_N];
    logic [HPM_N-1:0]   evt_of;
    logic [HPM_N-1:0]   evt_of_d;
    logic [HPM_N-1:0]   evt_we;
    logic [HPM_N-1:0]   hpm_wrap;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_we_lo;
    logic [NUM_CNT-1:0] cnt_we_hi;
    logic [NUM_CNT-1:0] cnt_inc_en;
    logic               inhibit_we;
    logic               is_write;
    logic [31:0]        wval;

    assign is_write = csr_is_write(csr_cmd_i);
    // rdata_o is the old value of whichever register is addressed, so it doubles as the RMW source.
    assign wval     = csr_modify(csr_cmd_i, rdata_o, wdata_i);

    always_comb begin
        logic [63:0] cnt_ext;
        logic [31:0] evt_rd;
        cnt_ext    = '0;
        evt_rd     = '0;
        rdata_o    = '0;
        hit_o      = 1'b0;
        inhibit_we = 1'b0;
        evt_we     = '0;
        cnt_we_lo  = '0;
        cnt_we_hi  = '0;
        if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
            hit_o      = 1'b1;
            rdata_o    = inhibit;
            inhibit_we = is_write;
        end
        for (int k = 0; k < NUM_HPM; k++) begin
            if (csr_addr_i == CSR_MHPMEVENT3 + 12'(k)) begin
                evt_rd             = '0;
                evt_rd[EVW-1:0]    = evt_sel[k];
                evt_rd[HPM_OF_BIT] = evt_of[k];
                hit_o              = 1'b1;
                rdata_o            = evt_rd;
                evt_we[k]          = is_write;
            end
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_ext = 64'(cnt_val[i]);
            if (i != IDX_TIME) begin
                if (csr_addr_i == CSR_MCYCLE + 12'(i)) begin
                    hit_o        = 1'b1;
                    rdata_o      = cnt_ext[31:0];
                    cnt_we_lo[i] = is_write;
                end
                if (csr_addr_i == CSR_MCYCLEH + 12'(i)) begin
                    hit_o        = 1'b1;
                    rdata_o      = cnt_ext[63:32];
                    cnt_we_hi[i] = is_write;
                end
                // User shadows are read-only: they hit but never raise a write enable.
                if (csr_addr_i == CSR_CYCLE + 12'(i)) begin
                    hit_o   = 1'b1;
                    rdata_o = cnt_ext[31:0];
                end
                if (csr_addr_i == CSR_CYCLEH + 12'(i)) begin
                    hit_o   = 1'b1;
                    rdata_o = cnt_ext[63:32];
                end
            end
        end
    end

    always_comb begin
        cnt_inc_en              = '0;
        cnt_inc_en[IDX_CYCLE]   = !inhibit[IDX_CYCLE] && !stop_counters_i;
        cnt_inc_en[IDX_INSTRET] = !inhibit[IDX_INSTRET] && !stop_counters_i;
        // A selector above NUM_EVENTS matches no strobe, which is the same as selecting nothing.
        for (int k = 0; k < NUM_HPM; k++) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (evt_sel[k] == EVW'(e + 1) && event_i[e]
                    && !inhibit[IDX_HPM_BASE+k] && !stop_counters_i) begin
                    cnt_inc_en[IDX_HPM_BASE+k] = 1'b1;
                end
            end
        end
    end

    // A wrap in the same cycle as a software clear of OF leaves OF set.
    always_comb begin
        evt_of_d = evt_of | hpm_wrap;
        for (int k = 0; k < NUM_HPM; k++) begin
            if (evt_we[k]) begin
                evt_of_d[k] = wval[HPM_OF_BIT] | hpm_wrap[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            inhibit   <= INHIBIT_RESET & INHIBIT_MASK;
            evt_of    <= '0;
            ovf_irq_o <= 1'b0;
            for (int k = 0; k < HPM_N; k++) begin
                evt_sel[k] <= '0;
            end
        end else begin
            if (inhibit_we) begin
                inhibit <= wval & INHIBIT_MASK;
            end
            evt_of    <= evt_of_d;
            ovf_irq_o <= |evt_of_d;
            for (int k = 0; k < NUM_HPM; k++) begin
                if (evt_we[k]) begin
                    evt_sel[k] <= wval[EVW-1:0];
                end
            end
        end
    end

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_wrap = '0;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        if (i == IDX_TIME) begin : g_time
            assign cnt_val[i] = '0;
        end else if (i == IDX_INSTRET) begin : g_instret
            hpm_counter #(.CNT_W(CNT_W), .INC_W(RETIRE_W)) u_cnt (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .we_lo    (cnt_we_lo[i]),
                .we_hi    (cnt_we_hi[i]),
                .wdata    (wval),
                .inc_en   (cnt_inc_en[i]),
                .inc      (instret_inc_i),
                .value    (cnt_val[i]),
                .wrap     ()
            );
        end else if (i == IDX_CYCLE) begin : g_cycle
            hpm_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .we_lo    (cnt_we_lo[i]),
                .we_hi    (cnt_we_hi[i]),
                .wdata    (wval),
                .inc_en   (cnt_inc_en[i]),
                .inc      (1'b1),
                .value    (cnt_val[i]),
                .wrap     ()
            );
        end else begin : g_hpm
            hpm_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .we_lo    (cnt_we_lo[i]),
                .we_hi    (cnt_we_hi[i]),
                .wdata    (wval),
                .inc_en   (cnt_inc_en[i]),
                .inc      (1'b1),
                .value    (cnt_val[i]),
                .wrap     (hpm_wrap[i-IDX_HPM_BASE])
            );
        end
    end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Bench for csr_hpm_counters: directed scenarios plus random CSR traffic, all
// compared against an architectural model of the counter registers.
module tb_csr_hpm_counters;
    import csr_hpm_counters_pkg::*;

    localparam int NUM_HPM    = 4;
    localparam int CNT_W      = 40;
    localparam int NUM_EVENTS = 8;
    localparam int RETIRE_W   = 2;
    localparam int EVW        = 4;
    localparam longint unsigned CMASK = (64'h1 << CNT_W) - 64'h1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    csr_op_e               csr_cmd = CSR_READ;
    logic [11:0]           csr_addr = 12'hB00;
    logic [31:0]           wdata = '0;
    logic                  stop_counters = 1'b0;
    logic [RETIRE_W-1:0]   instret_inc = '0;
    logic [NUM_EVENTS-1:0] event_v = '0;
    logic [31:0]           rdata;
    logic                  hit;
    logic                  ovf_irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_rdata;
    logic        last_hit;
    logic        last_irq;
    logic [31:0] frozen;

    // Architectural state, indexed by CSR counter number (0 = cycle, 2 = instret, 3.. = hpm).
    longint unsigned m_cnt [32];
    int              m_sel [NUM_HPM];
    bit              m_of  [NUM_HPM];
    logic [31:0]     m_inh;
    logic [31:0]     m_inh_mask;
    bit              m_irq;

    logic [11:0] addrs [26] = '{12'h320, 12'h321, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327,
                                12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB06, 12'hB07,
                                12'hB80, 12'hB82, 12'hB83, 12'hB86, 12'hC00, 12'hC01, 12'hC02,
                                12'hC03, 12'hC81, 12'hC83, 12'hC87, 12'h300};

    csr_hpm_counters #(
        .NUM_HPM       (NUM_HPM),
        .CNT_W         (CNT_W),
        .NUM_EVENTS    (NUM_EVENTS),
        .RETIRE_W      (RETIRE_W),
        .INHIBIT_RESET (32'h0)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .csr_cmd_i       (csr_cmd),
        .csr_addr_i      (csr_addr),
        .wdata_i         (wdata),
        .stop_counters_i (stop_counters),
        .instret_inc_i   (instret_inc),
        .event_i         (event_v),
        .rdata_o         (rdata),
        .hit_o           (hit),
        .ovf_irq_o       (ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void mread(input logic [11:0] a, output bit h, output logic [31:0] d);
        int ai, page, idx;
        ai   = int'(a);
        page = ai & 'hF80;
        idx  = ai & 'h7F;
        h    = 1'b0;
        d    = '0;
        if (ai == 'h320) begin
            h = 1'b1;
            d = m_inh;
        end else if (ai >= 'h323 && ai < 'h323 + NUM_HPM) begin
            h = 1'b1;
            d = 32'(m_sel[ai-'h323]) | (m_of[ai-'h323] ? 32'h8000_0000 : 32'h0);
        end else if ((page == 'hB00 || page == 'hB80 || page == 'hC00 || page == 'hC80)
                     && (idx == 0 || idx == 2 || (idx >= 3 && idx < 3 + NUM_HPM))) begin
            h = 1'b1;
            d = (page == 'hB80 || page == 'hC80) ? 32'(m_cnt[idx] >> 32) : 32'(m_cnt[idx]);
        end
    endfunction

    function automatic void mstep(input csr_op_e cmd, input logic [11:0] a, input logic [31:0] wd,
                                  input bit stop, input int inc, input logic [NUM_EVENTS-1:0] ev);
        bit              h, wr;
        logic [31:0]     old, nv;
        int              ai, page, idx, cw, s;
        longint unsigned nxt [32];
        bit              ovf [NUM_HPM];
        ai   = int'(a);
        page = ai & 'hF80;
        idx  = ai & 'h7F;
        mread(a, h, old);
        wr = h && (cmd != CSR_READ);
        case (cmd)
            WRITE_CSR: nv = wd;
            SET_CSR:   nv = old | wd;
            CLEAR_CSR: nv = old & ~wd;
            default:   nv = old;
        endcase
        cw  = (wr && (page == 'hB00 || page == 'hB80)) ? idx : -1;
        nxt = m_cnt;
        for (int k = 0; k < NUM_HPM; k++) ovf[k] = 1'b0;
        if (!stop) begin
            if (!m_inh[0] && cw != 0) nxt[0] = (m_cnt[0] + 1) & CMASK;
            if (!m_inh[2] && cw != 2) nxt[2] = (m_cnt[2] + longint'(inc)) & CMASK;
            for (int k = 0; k < NUM_HPM; k++) begin
                s = m_sel[k];
                if (!m_inh[3+k] && cw != 3 + k && s >= 1 && s <= NUM_EVENTS && ev[s-1]) begin
                    ovf[k]   = (m_cnt[3+k] == CMASK);
                    nxt[3+k] = (m_cnt[3+k] + 1) & CMASK;
                end
            end
        end
        if (cw >= 0) begin
            if (page == 'hB00) nxt[cw] = (m_cnt[cw] & 64'hFFFF_FFFF_0000_0000) | {32'h0, nv};
            else nxt[cw] = ((m_cnt[cw] & 64'hFFFF_FFFF) | ({32'h0, nv} << 32)) & CMASK;
        end
        for (int k = 0; k < NUM_HPM; k++) begin
            if (wr && ai == 'h323 + k) begin
                m_sel[k] = int'(nv[EVW-1:0]);
                m_of[k]  = nv[31] | ovf[k];
            end else begin
                m_of[k] = m_of[k] | ovf[k];
            end
        end
        if (wr && ai == 'h320) m_inh = nv & m_inh_mask;
        m_cnt = nxt;
        m_irq = 1'b0;
        for (int k = 0; k < NUM_HPM; k++) m_irq = m_irq | m_of[k];
    endfunction

    // One clock: drive at the falling edge, compare the pre-update outputs, advance the model.
    task automatic step(input csr_op_e cmd, input logic [11:0] a, input logic [31:0] wd,
                        input logic stop, input logic [RETIRE_W-1:0] inc,
                        input logic [NUM_EVENTS-1:0] ev);
        bit          eh;
        logic [31:0] ed;
        csr_cmd       = cmd;
        csr_addr      = a;
        wdata         = wd;
        stop_counters = stop;
        instret_inc   = inc;
        event_v       = ev;
        #1;
        mread(a, eh, ed);
        check($sformatf("hit@%h", a), 64'(hit), 64'(eh));
        check($sformatf("rdata@%h", a), 64'(rdata), 64'(ed));
        check("ovf_irq", 64'(ovf_irq), 64'(m_irq));
        last_rdata = rdata;
        last_hit   = hit;
        last_irq   = ovf_irq;
        mstep(cmd, a, wd, stop, int'(inc), ev);
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a);
        step(CSR_READ, a, 32'h0, 1'b0, '0, '0);
    endtask

    task automatic wr(input csr_op_e cmd, input logic [11:0] a, input logic [31:0] wd);
        step(cmd, a, wd, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        for (int k = 0; k < NUM_HPM; k++) begin
            m_sel[k] = 0;
            m_of[k]  = 1'b0;
        end
        m_inh_mask = 32'h5;
        for (int k = 0; k < NUM_HPM; k++) m_inh_mask[3+k] = 1'b1;
        m_inh = 32'h0;
        m_irq = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_mcycle", 64'(rdata), 64'h0);
        check("reset_irq", 64'(ovf_irq), 64'h0);
        rst_n = 1'b1;

        // Idle count after reset
        repeat (10) rd(CSR_MCYCLE);
        rd(CSR_MCYCLE);
        check("mcycle_10", 64'(last_rdata), 64'd10);
        rd(CSR_MCYCLEH);
        check("mcycleh_0", 64'(last_rdata), 64'h0);
        rd(CSR_MINSTRET);
        check("minstret_0", 64'(last_rdata), 64'h0);
        check("irq_idle", 64'(last_irq), 64'h0);
        rd(12'h327);
        check("hit_unimpl_evt", 64'(last_hit), 64'h0);
        check("rdata_unimpl_evt", 64'(last_rdata), 64'h0);
        rd(12'hC01);
        check("hit_time", 64'(last_hit), 64'h0);

        // 40-bit wrap of mcycle
        wr(WRITE_CSR, CSR_MCYCLE, 32'hFFFF_FFFF);
        wr(WRITE_CSR, CSR_MCYCLEH, 32'h0000_00FF);
        rd(CSR_MCYCLEH);
        check("mcycleh_ff", 64'(last_rdata), 64'hFF);
        rd(CSR_MCYCLE);
        check("mcycle_wrapped", 64'(last_rdata), 64'h0);
        rd(CSR_MCYCLEH);
        check("mcycleh_wrapped", 64'(last_rdata), 64'h0);
        wr(WRITE_CSR, CSR_MCYCLEH, 32'hFFFF_FFFF);
        rd(CSR_MCYCLEH);
        check("mcycleh_width", 64'(last_rdata), 64'hFF);

        // Multi-retire with inhibit arriving mid-burst
        wr(WRITE_CSR, CSR_MINSTRET, 32'h0);
        step(CSR_READ, CSR_MINSTRET, 32'h0, 1'b0, 2'd3, '0);
        step(WRITE_CSR, CSR_MCOUNTINHIBIT, 32'h4, 1'b0, 2'd3, '0);
        step(CSR_READ, CSR_MINSTRET, 32'h0, 1'b0, 2'd3, '0);
        step(CSR_READ, CSR_MINSTRET, 32'h0, 1'b0, 2'd3, '0);
        rd(CSR_MINSTRET);
        check("minstret_6", 64'(last_rdata), 64'd6);
        wr(WRITE_CSR, CSR_MCOUNTINHIBIT, 32'h0);

        // hpm3 overflow and interrupt
        wr(WRITE_CSR, CSR_MHPMEVENT3, 32'h2);
        wr(WRITE_CSR, CSR_MHPMCOUNTER3, 32'hFFFF_FFFF);
        wr(WRITE_CSR, CSR_MHPMCOUNTER3 + 12'h80, 32'hFF);
        step(CSR_READ, CSR_MHPMCOUNTER3, 32'h0, 1'b0, '0, 8'h02);
        rd(CSR_MHPMCOUNTER3);
        check("hpm3_wrapped", 64'(last_rdata), 64'h0);
        check("irq_set", 64'(last_irq), 64'h1);
        rd(CSR_MHPMEVENT3);
        check("evt3_of", 64'(last_rdata), 64'h8000_0002);
        wr(WRITE_CSR, CSR_MHPMEVENT3, 32'h2);
        rd(CSR_MHPMEVENT3);
        check("irq_cleared", 64'(last_irq), 64'h0);
        check("evt3_cleared", 64'(last_rdata), 64'h2);

        // Overflow coinciding with a software clear of OF
        wr(WRITE_CSR, CSR_MHPMCOUNTER3, 32'hFFFF_FFFF);
        wr(WRITE_CSR, CSR_MHPMCOUNTER3 + 12'h80, 32'hFF);
        wr(SET_CSR, CSR_MHPMEVENT3, 32'h8000_0000);
        step(CLEAR_CSR, CSR_MHPMEVENT3, 32'h8000_0000, 1'b0, '0, 8'h02);
        rd(CSR_MHPMEVENT3);
        check("of_wins_clear", 64'(last_rdata), 64'h8000_0002);
        check("irq_of_wins", 64'(last_irq), 64'h1);
        wr(CLEAR_CSR, CSR_MHPMEVENT3, 32'h8000_0000);
        rd(CSR_MHPMEVENT3);
        check("of_clear_only", 64'(last_rdata), 64'h2);
        check("irq_clear_only", 64'(last_irq), 64'h0);

        // Writing the counter in the overflow cycle suppresses the increment and OF
        wr(WRITE_CSR, CSR_MHPMCOUNTER3, 32'hFFFF_FFFF);
        wr(WRITE_CSR, CSR_MHPMCOUNTER3 + 12'h80, 32'hFF);
        step(WRITE_CSR, CSR_MHPMCOUNTER3 + 12'h80, 32'hFF, 1'b0, '0, 8'h02);
        rd(CSR_MHPMEVENT3);
        check("no_of_on_write", 64'(last_rdata), 64'h2);
        rd(CSR_MHPMCOUNTER3);
        check("hpm3_held", 64'(last_rdata), 64'hFFFF_FFFF);

        // Inhibit and debug stop both freeze mcycle; shadow writes are dropped
        step(SET_CSR, CSR_MCOUNTINHIBIT, 32'h1, 1'b1, '0, '0);
        rd(CSR_MCYCLE);
        frozen = last_rdata;
        step(CSR_READ, CSR_MCYCLE, 32'h0, 1'b1, '0, '0);
        step(CSR_READ, CSR_MCYCLE, 32'h0, 1'b0, '0, '0);
        step(CSR_READ, CSR_MCYCLE, 32'h0, 1'b1, '0, '0);
        rd(CSR_MCYCLE);
        check("mcycle_frozen", 64'(last_rdata), 64'(frozen));
        wr(WRITE_CSR, CSR_CYCLE, 32'h1234);
        check("shadow_hit", 64'(last_hit), 64'h1);
        rd(CSR_MCYCLE);
        check("shadow_no_write", 64'(last_rdata), 64'(frozen));
        wr(WRITE_CSR, CSR_MCOUNTINHIBIT, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            csr_op_e     c;
            logic [11:0] a;
            logic [31:0] d;
            c = csr_op_e'($urandom_range(0, 3));
            a = addrs[$urandom_range(0, 25)];
            if ($urandom_range(0, 15) == 0) a = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFFF;
                1:       d = $urandom_range(0, 9);
                default: d = $urandom;
            endcase
            step(c, a, d, ($urandom_range(0, 7) == 0), RETIRE_W'($urandom),
                 NUM_EVENTS'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
